// File: rtl/serial_sync_pkg.sv
// Shared types and constants for the sync-strobe serial receiver.
// Provides the FSM state encoding, default sizes and a gap-width helper.
package serial_sync_pkg;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_e;

   localparam int DEF_WIDTH  = 8;
   localparam int DEF_PERIOD = 3;

   // Gap counter must hold 0..period inclusive.
   function automatic int gap_w(input int period);
      return $clog2(period + 1);
   endfunction

endpackage

// File: rtl/serial_sync_hold.sv
// Single-entry valid/ready holding register with drop-on-full overflow.
// Ports: clk, reset (async, active-high), in_valid/in_data (one-cycle
// word offer, never stalled), ready_in, data_out, valid_out, overflow.
module serial_sync_hold import serial_sync_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             ready_in,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out,
   output logic             overflow
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             ovf_q, ovf_d;
   logic             load;

   // The producer cannot stall, so a word offered into a full,
   // non-draining buffer is lost and flagged.
   always_comb begin
      load    = in_valid && (!valid_q || ready_in);
      data_d  = data_q;
      valid_d = valid_q;
      ovf_d   = ovf_q;
      if (load) begin
         data_d  = in_data;
         valid_d = 1'b1;
      end else if (in_valid) begin
         ovf_d = 1'b1;
      end else if (valid_q && ready_in) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

   assign data_out  = data_q;
   assign valid_out = valid_q;
   assign overflow  = ovf_q;

endmodule

// File: rtl/serial_sync_rx.sv
// Receiver for the 1-bit data + sync-strobe link: checks strobe spacing,
// assembles WIDTH bits LSB-first and hands words to a 1-entry buffer.
// Ports: clk, reset (async, active-high), sd_in, sync_in, data_out,
// valid_out, ready_in, frame_err (1-cycle pulse), overflow (sticky).
module serial_sync_rx import serial_sync_pkg::*; #(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int PERIOD = DEF_PERIOD
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sd_in,
   input  logic             sync_in,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out,
   input  logic             ready_in,
   output logic             frame_err,
   output logic             overflow
);

   localparam int GW = gap_w(PERIOD);
   localparam int BW = $clog2(WIDTH + 1);

   localparam logic [GW-1:0] GAP_EXP  = GW'(PERIOD - 1);
   localparam logic [GW-1:0] GAP_MAX  = GW'(PERIOD);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [GW-1:0]    gap_q, gap_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic             ferr_q, ferr_d;
   logic [WIDTH-1:0] word;
   logic             word_done;
   logic             on_time;

   always_comb begin
      gap_d = gap_q;
      if (sync_in) begin
         gap_d = '0;
      end else if (gap_q != GAP_MAX) begin
         gap_d = gap_q + GW'(1);
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      ferr_d    = 1'b0;
      word_done = 1'b0;
      on_time   = (gap_q == GAP_EXP);
      // Bit slot bit_cnt_q is still zero, so OR-in places the bit.
      word = shift_q | (WIDTH'(sd_in) << bit_cnt_q);
      unique case (state_q)
         HUNT: begin
            if (sync_in) begin
               state_d   = LOCKED;
               shift_d   = WIDTH'(sd_in);
               bit_cnt_d = BW'(1);
            end
         end
         LOCKED: begin
            if (sync_in && on_time) begin
               if (bit_cnt_q == BIT_LAST) begin
                  word_done = 1'b1;
                  shift_d   = '0;
                  bit_cnt_d = '0;
               end else begin
                  shift_d   = word;
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end else if (sync_in) begin
               // Early strobe: resynchronise on it.
               ferr_d    = 1'b1;
               shift_d   = WIDTH'(sd_in);
               bit_cnt_d = BW'(1);
            end else if (on_time) begin
               ferr_d    = 1'b1;
               state_d   = HUNT;
               shift_d   = '0;
               bit_cnt_d = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= HUNT;
         gap_q     <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         gap_q     <= gap_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         ferr_q    <= ferr_d;
      end
   end

   assign frame_err = ferr_q;

   serial_sync_hold #(
      .WIDTH(WIDTH)
   ) u_hold (
      .clk      (clk),
      .reset    (reset),
      .in_valid (word_done),
      .in_data  (word),
      .ready_in (ready_in),
      .data_out (data_out),
      .valid_out(valid_out),
      .overflow (overflow)
   );

endmodule

// File: tb/tb_serial_sync_rx.sv
// Directed bench for serial_sync_rx with a strobe-timing model.
// WIDTH=4, PERIOD=3; every cycle is compared plus literal checkpoints.
module tb_serial_sync_rx;

   localparam int W = 4;
   localparam int P = 3;

   logic         clk      = 1'b0;
   logic         reset    = 1'b0;
   logic         sd_in    = 1'b0;
   logic         sync_in  = 1'b0;
   logic         ready_in = 1'b0;
   logic [W-1:0] data_out;
   logic         valid_out;
   logic         frame_err;
   logic         overflow;

   int n_vec = 0;
   int n_mis = 0;

   serial_sync_rx #(
      .WIDTH (W),
      .PERIOD(P)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .sd_in    (sd_in),
      .sync_in  (sync_in),
      .data_out (data_out),
      .valid_out(valid_out),
      .ready_in (ready_in),
      .frame_err(frame_err),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   // Model: strobe timing by absolute cycle number, word by arithmetic.
   bit           m_locked  = 1'b0;
   int           m_cyc     = 0;
   int           m_last    = 0;
   int           m_n       = 0;
   int           m_acc     = 0;
   logic [W-1:0] exp_data  = '0;
   bit           exp_valid = 1'b0;
   bit           exp_ovf   = 1'b0;
   bit           exp_ferr  = 1'b0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_locked  <= 1'b0;
         m_n       <= 0;
         m_acc     <= 0;
         m_last    <= 0;
         exp_data  <= '0;
         exp_valid <= 1'b0;
         exp_ovf   <= 1'b0;
         exp_ferr  <= 1'b0;
      end else begin
         automatic bit           lk   = m_locked;
         automatic int           n    = m_n;
         automatic int           acc  = m_acc;
         automatic int           last = m_last;
         automatic bit           fe   = 1'b0;
         automatic bit           done = 1'b0;
         automatic int           wd   = 0;
         automatic bit           v    = exp_valid;
         automatic bit           ov   = exp_ovf;
         automatic logic [W-1:0] dq   = exp_data;
         if (!lk) begin
            if (sync_in) begin
               lk   = 1'b1;
               n    = 1;
               acc  = int'(sd_in);
               last = m_cyc;
            end
         end else if (sync_in) begin
            if (m_cyc - last != P) begin
               fe  = 1'b1;
               n   = 0;
               acc = 0;
            end
            acc  = acc + (int'(sd_in) << n);
            n    = n + 1;
            last = m_cyc;
         end else if (m_cyc - last == P) begin
            fe  = 1'b1;
            lk  = 1'b0;
            n   = 0;
            acc = 0;
         end
         if (n == W) begin
            wd   = acc;
            done = 1'b1;
            n    = 0;
            acc  = 0;
         end
         if (done) begin
            if (!v || ready_in) begin
               v  = 1'b1;
               dq = W'(wd);
            end else begin
               ov = 1'b1;
            end
         end else if (v && ready_in) begin
            v = 1'b0;
         end
         m_locked  <= lk;
         m_n       <= n;
         m_acc     <= acc;
         m_last    <= last;
         exp_ferr  <= fe;
         exp_valid <= v;
         exp_ovf   <= ov;
         exp_data  <= dq;
      end
      if (!reset) m_cyc <= m_cyc + 1;
   end

   task automatic check(input string nm,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h want %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("valid_out", 32'(valid_out), 32'(exp_valid));
      check("data_out",  32'(data_out),  32'(exp_data));
      check("frame_err", 32'(frame_err), 32'(exp_ferr));
      check("overflow",  32'(overflow),  32'(exp_ovf));
   end

   task automatic step(input bit s, input bit d, input bit r);
      @(negedge clk);
      sync_in  = s;
      sd_in    = d;
      ready_in = r;
   endtask

   task automatic send_bit(input bit d, input bit r);
      step(1'b1, d, r);
      step(1'b0, 1'b0, r);
      step(1'b0, 1'b0, r);
   endtask

   // Strobe then land just after the capturing edge.
   task automatic sync_then(input bit d, input bit r);
      step(1'b1, d, r);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2 reset = 1'b1;
      #1;
      check("rst_valid", 32'(valid_out), 32'd0);
      check("rst_data",  32'(data_out),  32'd0);
      check("rst_ovf",   32'(overflow),  32'd0);
      @(negedge clk);
      reset = 1'b0;
      step(0, 0, 0);
      step(0, 0, 0);

      // Basic word 1,0,1,1 -> 4'b1101, latency one cycle
      send_bit(1, 0);
      send_bit(0, 0);
      send_bit(1, 0);
      step(1, 1, 0);
      #1;
      check("t1_pre_valid", 32'(valid_out), 32'd0);
      @(posedge clk);
      #1;
      check("t1_valid", 32'(valid_out), 32'd1);
      check("t1_data",  32'(data_out),  32'hD);
      check("t1_ferr",  32'(frame_err), 32'd0);
      step(0, 0, 1);
      step(0, 0, 1);

      // Continuous alternating stream -> 4'b0101 words
      repeat (2) begin
         send_bit(1, 1);
         send_bit(0, 1);
         send_bit(1, 1);
         send_bit(0, 1);
      end
      check("t2_data", 32'(data_out), 32'h5);
      check("t2_ovf",  32'(overflow), 32'd0);

      // Early strobe after two good bits
      send_bit(0, 1);
      step(1, 1, 1);
      step(0, 0, 1);
      sync_then(0, 1);
      check("t3_ferr", 32'(frame_err), 32'd1);
      step(0, 0, 1);
      step(0, 0, 1);
      send_bit(1, 1);
      send_bit(1, 1);
      sync_then(0, 1);
      check("t3_valid", 32'(valid_out), 32'd1);
      check("t3_data",  32'(data_out),  32'h6);
      step(0, 0, 1);
      step(0, 0, 1);

      // Missing strobe after two bits
      send_bit(1, 1);
      send_bit(1, 1);
      step(0, 0, 1);
      @(posedge clk);
      #1;
      check("t4_ferr", 32'(frame_err), 32'd1);
      step(0, 0, 1);
      step(0, 0, 1);
      send_bit(0, 1);
      send_bit(0, 1);
      send_bit(1, 1);
      sync_then(1, 1);
      check("t4_data", 32'(data_out), 32'hC);
      step(0, 0, 1);
      step(0, 0, 1);

      // Back-pressure: second word dropped
      send_bit(1, 0);
      send_bit(0, 0);
      send_bit(0, 0);
      send_bit(1, 0);
      send_bit(0, 0);
      send_bit(1, 0);
      send_bit(1, 0);
      send_bit(1, 0);
      check("t5_valid", 32'(valid_out), 32'd1);
      check("t5_data",  32'(data_out),  32'h9);
      check("t5_ovf",   32'(overflow),  32'd1);
      step(0, 0, 1);
      @(posedge clk);
      #1;
      check("t5_drain", 32'(valid_out), 32'd0);
      check("t5_stick", 32'(overflow),  32'd1);
      check("t5_keep",  32'(data_out),  32'h9);
      step(0, 0, 0);
      step(0, 0, 0);

      // Async reset mid-word with a buffered word
      send_bit(1, 0);
      send_bit(1, 0);
      send_bit(1, 0);
      send_bit(1, 0);
      send_bit(1, 0);
      send_bit(0, 0);
      check("t6_held", 32'(data_out), 32'hF);
      #2 reset = 1'b1;
      #1;
      check("t6_valid", 32'(valid_out), 32'd0);
      check("t6_data",  32'(data_out),  32'd0);
      check("t6_ovf",   32'(overflow),  32'd0);
      check("t6_ferr",  32'(frame_err), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      step(0, 0, 1);
      send_bit(0, 1);
      send_bit(1, 1);
      send_bit(0, 1);
      sync_then(1, 1);
      check("t6_valid2", 32'(valid_out), 32'd1);
      check("t6_data2",  32'(data_out),  32'hA);
      repeat (6) step(0, 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/serial_sync_rx.md
Name: serial_sync_rx

Overview:
Receiver for the team's 1-bit data + sync-strobe serial link. The transmitter asserts sync for one cycle every PERIOD cycles and drives the data bit on the same cycle. This block samples sd_in on each sync strobe and checks strobe spacing. It assembles WIDTH bits LSB-first into a word and presents the word on a valid/ready output port with one-word buffering and error/overflow reporting.

Parameters:
WIDTH, 8, bits per received word (2..32)
PERIOD, 3, required cycle spacing between consecutive sync strobes (2..15)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
sd_in  in  1  serial data bit, valid only when sync_in=1
sync_in  in  1  sync strobe, one cycle wide
data_out  out  WIDTH  received word, bit 0 = first bit received
valid_out  out  1  data_out holds an unconsumed word
ready_in  in  1  consumer accepts data_out when valid_out && ready_in
frame_err  out  1  one-cycle pulse, strobe spacing violation
overflow  out  1  sticky, a completed word was dropped

Behaviour:
- Reset is async, active-high. Clock is clk. On reset: state=HUNT, gap=0, bit_cnt=0, shift=0, data_out=0, valid_out=0, frame_err=0, overflow=0. Reset mid-word discards the partial word and any buffered word.
- gap counter: clog2(PERIOD+1) bits. Clears on a sync cycle. Otherwise increments and saturates at PERIOD.
- HUNT state:
  - Ignore everything until sync_in=1.
  - On that cycle: capture sd_in as bit 0, set bit_cnt=1, clear gap, go to LOCKED.
- LOCKED state: a sync is expected on the cycle where gap==PERIOD-1.
  - sync_in=1 and gap==PERIOD-1: capture sd_in at position bit_cnt, increment bit_cnt.
  - sync_in=1 and gap!=PERIOD-1 (early): frame_err pulses on the next cycle. Discard the partial word. Capture this bit as bit 0 of a new word (bit_cnt=1). Stay in LOCKED.
  - sync_in=0 and gap==PERIOD-1 (missing strobe): frame_err pulses on the next cycle. Discard the partial word and go to HUNT.
- Word completion: the capture that makes bit_cnt reach WIDTH completes the word. bit_cnt then resets to 0 and the block stays in LOCKED.
  - The word reaches data_out and valid_out rises one cycle after the completing sync cycle.
- Output buffer (single entry):
  - Load when the buffer is empty, or when valid_out && ready_in on the completion cycle. In the second case valid_out stays 1 and data_out updates.
  - If a word completes while valid_out=1 and ready_in=0: drop the new word, keep the old word, set overflow. overflow clears only on reset.
  - valid_out && ready_in with no completion: valid_out falls next cycle. data_out keeps its last value.
  - data_out must be stable while valid_out && !ready_in.
- sd_in is don't-care when sync_in=0.
- Total latency: one cycle from the last-bit sync cycle to valid_out=1.

Decomposition:
- Package serial_sync_pkg: state encoding (HUNT, LOCKED), default WIDTH/PERIOD constants, gap counter width function.
- One sub-module, serial_sync_hold: single-entry valid/ready holding register with drop-on-full overflow flag. The top level contains the FSM, gap counter and shift assembly.

Test Plan:
- Sync every 3 cycles, WIDTH=4, bits 1,0,1,1 -> data_out=4'b1101, valid_out=1 one cycle after 4th sync, frame_err never asserted.
- Free-running strobe pattern, bits alternating 1,0,1,0,... with ready_in=1 -> continuous words 4'b0101, one valid per 12 cycles, no overflow.
- Sync arrives 2 cycles after previous (PERIOD=3) mid-word -> frame_err pulse, partial word dropped, next 4 good syncs produce a word starting with the early bit.
- Strobe omitted after 2nd bit -> frame_err pulse at expected slot +1, state HUNT. Next sync restarts at bit 0 and the correct word follows.
- ready_in=0 across two completed words -> first word held stable, second dropped, overflow=1. Then ready_in=1 -> valid_out falls and overflow stays 1 until reset.
- Assert reset between 2nd and 3rd bit, with a word also buffered -> all outputs 0 immediately (async). The post-reset stream decodes from bit 0.
